// File: rtl/tt_sweep_checker.sv
// Purpose: sweeps all 2^N_IN input vectors of a combinational block, captures its truth table, compares to expected.
// Latency: 2^N_IN*(SETTLE+1) cycles from accepted start to done.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
module tt_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected_i,
    output logic [N_IN-1:0]       stim_o,
    input  logic                  dut_y_i,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_o,
    output logic                  match,
    output logic [N_IN:0]         mismatch_cnt,
    output logic [N_IN-1:0]       first_bad
);

    localparam int ROWS = 1 << N_IN;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // With no settle time the DRIVE state is skipped entirely.
    localparam logic [1:0] ST_FIRST    = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;
    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ROWS-1:0]   table_q, table_d;
    logic [ROWS-1:0]   exp_q, exp_d;
    logic [N_IN:0]     mcnt_q, mcnt_d;
    logic [N_IN-1:0]   first_bad_q, first_bad_d;
    logic              match_q, match_d;
    logic              row_bad;

    // Next-state and datapath update for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        cnt_d       = cnt_q;
        table_d     = table_q;
        exp_d       = exp_q;
        mcnt_d      = mcnt_q;
        first_bad_d = first_bad_q;
        match_d     = match_q;
        row_bad     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_FIRST;
                    stim_d      = '0;
                    cnt_d       = '0;
                    table_d     = '0;
                    exp_d       = expected_i;
                    mcnt_d      = '0;
                    first_bad_d = '0;
                    match_d     = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                table_d[stim_q] = dut_y_i;
                row_bad         = (dut_y_i != exp_q[stim_q]);
                if (row_bad) begin
                    mcnt_d = mcnt_q + (N_IN+1)'(1);
                    // Count still zero means this is the sweep's first bad row.
                    if (mcnt_q == '0) begin
                        first_bad_d = stim_q;
                    end
                end
                if (stim_q != LAST_VEC) begin
                    stim_d  = stim_q + N_IN'(1);
                    state_d = ST_FIRST;
                    cnt_d   = '0;
                end else begin
                    stim_d  = '0;
                    state_d = ST_DONE;
                    match_d = (mcnt_d == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stim_q      <= '0;
            cnt_q       <= '0;
            table_q     <= '0;
            exp_q       <= '0;
            mcnt_q      <= '0;
            first_bad_q <= '0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            cnt_q       <= cnt_d;
            table_q     <= table_d;
            exp_q       <= exp_d;
            mcnt_q      <= mcnt_d;
            first_bad_q <= first_bad_d;
            match_q     <= match_d;
        end
    end

    assign stim_o       = stim_q;
    assign busy         = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done         = (state_q == ST_DONE);
    assign table_o      = table_q;
    assign match        = match_q;
    assign mismatch_cnt = mcnt_q;
    assign first_bad    = first_bad_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Purpose: directed checks of tt_sweep_checker across four parameterisations.
// Latency: each sweep is checked at its exact completion edge.
// Backpressure: start pulses during busy and on the final sample edge must be ignored.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // N_IN=3, SETTLE=1, Y = ~stim[1]
    logic       st3;
    logic [7:0] exp3;
    logic [2:0] stim3;
    logic       y3, busy3, done3, match3;
    logic [7:0] tab3;
    logic [3:0] mc3;
    logic [2:0] fb3;
    assign y3 = ~stim3[1];

    // N_IN=4, SETTLE=0, Y = even parity
    logic        st_a;
    logic [15:0] exp_a;
    logic [3:0]  stim_a;
    logic        y_a, busy_a, done_a, match_a;
    logic [15:0] tab_a;
    logic [4:0]  mc_a;
    logic [3:0]  fb_a;
    assign y_a = ~^stim_a;

    // N_IN=4, SETTLE=2, Y stuck at 0
    logic        st_b;
    logic [15:0] exp_b;
    logic [3:0]  stim_b;
    logic        y_b, busy_b, done_b, match_b;
    logic [15:0] tab_b;
    logic [4:0]  mc_b;
    logic [3:0]  fb_b;
    assign y_b = 1'b0;

    // N_IN=1, SETTLE=15, Y = stim
    logic       st1;
    logic [1:0] exp1;
    logic [0:0] stim1;
    logic       y1, busy1, done1, match1;
    logic [1:0] tab1;
    logic [1:0] mc1;
    logic [0:0] fb1;
    assign y1 = stim1[0];

    tt_sweep_checker #(.N_IN(3), .SETTLE(1)) u_n3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .expected_i(exp3), .stim_o(stim3),
        .dut_y_i(y3), .busy(busy3), .done(done3), .table_o(tab3), .match(match3),
        .mismatch_cnt(mc3), .first_bad(fb3));

    tt_sweep_checker #(.N_IN(4), .SETTLE(0)) u_n4a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .expected_i(exp_a), .stim_o(stim_a),
        .dut_y_i(y_a), .busy(busy_a), .done(done_a), .table_o(tab_a), .match(match_a),
        .mismatch_cnt(mc_a), .first_bad(fb_a));

    tt_sweep_checker #(.N_IN(4), .SETTLE(2)) u_n4b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .expected_i(exp_b), .stim_o(stim_b),
        .dut_y_i(y_b), .busy(busy_b), .done(done_b), .table_o(tab_b), .match(match_b),
        .mismatch_cnt(mc_b), .first_bad(fb_b));

    tt_sweep_checker #(.N_IN(1), .SETTLE(15)) u_n1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .expected_i(exp1), .stim_o(stim1),
        .dut_y_i(y1), .busy(busy1), .done(done1), .table_o(tab1), .match(match1),
        .mismatch_cnt(mc1), .first_bad(fb1));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        st3 = 1'b0; st_a = 1'b0; st_b = 1'b0; st1 = 1'b0;
        exp3 = '0; exp_a = '0; exp_b = '0; exp1 = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst busy", 64'(busy_b), 64'd0);
        check_val("rst done", 64'(done_b), 64'd0);
        check_val("rst stim", 64'(stim_b), 64'd0);
        check_val("rst table", 64'(tab_b), 64'd0);
        check_val("rst match", 64'(match_b), 64'd0);
        check_val("rst mcnt", 64'(mc_b), 64'd0);
        check_val("rst first_bad", 64'(fb_b), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // N_IN=3 SETTLE=1: expected changed after start must not matter
        exp3 = 8'h33; st3 = 1'b1;
        tick(1);
        st3 = 1'b0; exp3 = 8'h00;
        check_val("n3 busy at k", 64'(busy3), 64'd1);
        check_val("n3 stim at k", 64'(stim3), 64'd0);
        tick(2);
        check_val("n3 stim at k+2", 64'(stim3), 64'd1);
        tick(13);
        check_val("n3 done at k+15", 64'(done3), 64'd0);
        tick(1);
        check_val("n3 done at k+16", 64'(done3), 64'd1);
        check_val("n3 busy at k+16", 64'(busy3), 64'd0);
        check_val("n3 table", 64'(tab3), 64'h33);
        check_val("n3 match", 64'(match3), 64'd1);
        check_val("n3 mcnt", 64'(mc3), 64'd0);
        check_val("n3 first_bad", 64'(fb3), 64'd0);
        check_val("n3 stim final", 64'(stim3), 64'd0);

        // N_IN=4 SETTLE=0 parity, matching table
        exp_a = 16'h9669; st_a = 1'b1;
        tick(1);
        st_a = 1'b0;
        check_val("n4a busy at k", 64'(busy_a), 64'd1);
        check_val("n4a stim at k", 64'(stim_a), 64'd0);
        tick(15);
        check_val("n4a done at k+15", 64'(done_a), 64'd0);
        check_val("n4a stim at k+15", 64'(stim_a), 64'd15);
        tick(1);
        check_val("n4a done at k+16", 64'(done_a), 64'd1);
        check_val("n4a match", 64'(match_a), 64'd1);
        check_val("n4a mcnt", 64'(mc_a), 64'd0);
        check_val("n4a table", 64'(tab_a), 64'h9669);

        // Same block, one wrong expected bit at row 0
        exp_a = 16'h9668; st_a = 1'b1;
        tick(1);
        st_a = 1'b0;
        check_val("n4a2 done falls", 64'(done_a), 64'd0);
        check_val("n4a2 table cleared", 64'(tab_a), 64'd0);
        tick(16);
        check_val("n4a2 done", 64'(done_a), 64'd1);
        check_val("n4a2 match", 64'(match_a), 64'd0);
        check_val("n4a2 mcnt", 64'(mc_a), 64'd1);
        check_val("n4a2 first_bad", 64'(fb_a), 64'd0);
        check_val("n4a2 table", 64'(tab_a), 64'h9669);

        // N_IN=4 SETTLE=2 stuck-at-0; start pulses at cycle 5 and on the last sample edge
        exp_b = 16'hF0F0; st_b = 1'b1;
        tick(1);
        st_b = 1'b0;
        for (int c = 0; c < 48; c++) begin
            check_val($sformatf("n4b stim c%0d", c), 64'(stim_b), 64'(c / 3));
            check_val($sformatf("n4b busy c%0d", c), 64'(busy_b), 64'd1);
            st_b = (c == 5 || c == 47) ? 1'b1 : 1'b0;
            tick(1);
        end
        st_b = 1'b0;
        check_val("n4b done at k+48", 64'(done_b), 64'd1);
        check_val("n4b busy at k+48", 64'(busy_b), 64'd0);
        check_val("n4b mcnt", 64'(mc_b), 64'd8);
        check_val("n4b first_bad", 64'(fb_b), 64'd4);
        check_val("n4b match", 64'(match_b), 64'd0);
        check_val("n4b table", 64'(tab_b), 64'd0);
        check_val("n4b stim final", 64'(stim_b), 64'd0);

        // Restart from DONE, then reset in the middle of vector 7
        st_b = 1'b1;
        tick(1);
        st_b = 1'b0;
        check_val("n4b restart done", 64'(done_b), 64'd0);
        check_val("n4b restart busy", 64'(busy_b), 64'd1);
        check_val("n4b restart mcnt", 64'(mc_b), 64'd0);
        check_val("n4b restart first_bad", 64'(fb_b), 64'd0);
        check_val("n4b restart match", 64'(match_b), 64'd0);
        tick(22);
        check_val("n4b stim before rst", 64'(stim_b), 64'd7);
        check_val("n4b mcnt before rst", 64'(mc_b), 64'd3);
        rst_n = 1'b0;
        #1;
        check_val("n4b async rst stim", 64'(stim_b), 64'd0);
        check_val("n4b async rst busy", 64'(busy_b), 64'd0);
        check_val("n4b async rst done", 64'(done_b), 64'd0);
        check_val("n4b async rst mcnt", 64'(mc_b), 64'd0);
        check_val("n4b async rst first_bad", 64'(fb_b), 64'd0);
        check_val("n4b async rst table", 64'(tab_b), 64'd0);
        check_val("n4b async rst match", 64'(match_b), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check_val("n4b idle busy", 64'(busy_b), 64'd0);
        check_val("n4b idle done", 64'(done_b), 64'd0);
        check_val("n4b idle stim", 64'(stim_b), 64'd0);

        exp_b = 16'h8000; st_b = 1'b1;
        tick(1);
        st_b = 1'b0;
        tick(47);
        check_val("n4b post-rst done k+47", 64'(done_b), 64'd0);
        tick(1);
        check_val("n4b post-rst done", 64'(done_b), 64'd1);
        check_val("n4b post-rst mcnt", 64'(mc_b), 64'd1);
        check_val("n4b post-rst first_bad", 64'(fb_b), 64'd15);
        check_val("n4b post-rst match", 64'(match_b), 64'd0);

        // N_IN=1 SETTLE=15 identity
        exp1 = 2'b10; st1 = 1'b1;
        tick(1);
        st1 = 1'b0;
        tick(15);
        check_val("n1 stim k+15", 64'(stim1), 64'd0);
        tick(1);
        check_val("n1 stim k+16", 64'(stim1), 64'd1);
        tick(15);
        check_val("n1 done k+31", 64'(done1), 64'd0);
        tick(1);
        check_val("n1 done k+32", 64'(done1), 64'd1);
        check_val("n1 busy k+32", 64'(busy1), 64'd0);
        check_val("n1 table", 64'(tab1), 64'd2);
        check_val("n1 match", 64'(match1), 64'd1);
        check_val("n1 mcnt", 64'(mc1), 64'd0);
        check_val("n1 first_bad", 64'(fb1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
